// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: credit-limited request generator, in-order response
// tracker with redirect drop counting, and a small {instr, pc} buffer to decode.
module instruction_fetch_stage #(
   parameter logic [63:0] RESET_PC   = 64'h0,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        branch_taken,
   input  logic [63:0] branch_target,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [63:0] if_pc
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [CW-1:0] DEPTH_CNT   = CW'(FIFO_DEPTH);
   localparam logic [CW:0]   DEPTH_SUM   = (CW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] ONE_CNT     = CW'(1);
   localparam logic [AW-1:0] ONE_PTR     = AW'(1);
   localparam logic [63:0]   START_PC    = {RESET_PC[63:2], 2'b00};
   localparam logic [31:0]   NOP_INSTR   = 32'h0000_0013;

   // Fetch-side state
   logic [63:0]   fetch_pc;
   logic [63:0]   resp_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;

   // Instruction buffer
   logic [31:0]   instr_mem [FIFO_DEPTH];
   logic [63:0]   pc_mem    [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] fifo_cnt;

   // Next-state / handshake terms
   logic          req_xfer;
   logic          rsp_seen;
   logic          push;
   logic          pop;
   logic          fifo_full;
   logic          credit_ok;
   logic [63:0]   redirect_pc;
   logic [CW-1:0] outstanding_nxt;
   logic [CW-1:0] drop_nxt;
   logic [CW-1:0] fifo_cnt_nxt;
   logic          target_lsb_unused;

   assign target_lsb_unused = ^branch_target[1:0];
   assign redirect_pc       = {branch_target[63:2], 2'b00};

   // Credits count both buffered entries and in-flight requests, so every
   // response that will be kept already has a slot reserved for it.
   assign credit_ok = ({1'b0, fifo_cnt} + {1'b0, outstanding}) < DEPTH_SUM;
   assign imem_req  = reset_n && credit_ok;
   assign imem_addr = fetch_pc;

   assign req_xfer  = imem_req && imem_gnt;
   assign rsp_seen  = imem_rvalid && (outstanding != '0);
   assign push      = rsp_seen && (drop_cnt == '0) && !branch_taken;
   assign pop       = if_valid && if_ready;
   assign fifo_full = (fifo_cnt == DEPTH_CNT);

   assign if_valid  = (fifo_cnt != '0);
   assign if_instr  = if_valid ? instr_mem[rd_ptr] : NOP_INSTR;
   assign if_pc     = if_valid ? pc_mem[rd_ptr]    : 64'h0;

   always_comb begin
      outstanding_nxt = outstanding;
      drop_nxt        = drop_cnt;
      fifo_cnt_nxt    = fifo_cnt;

      case ({req_xfer, rsp_seen})
         2'b10:   outstanding_nxt = outstanding + ONE_CNT;
         2'b01:   outstanding_nxt = outstanding - ONE_CNT;
         default: outstanding_nxt = outstanding;
      endcase

      // Everything still in flight after a redirect belongs to the old path.
      if (branch_taken) begin
         drop_nxt = outstanding_nxt;
      end else if (rsp_seen && (drop_cnt != '0)) begin
         drop_nxt = drop_cnt - ONE_CNT;
      end

      case ({push, pop})
         2'b10:   fifo_cnt_nxt = fifo_cnt + ONE_CNT;
         2'b01:   fifo_cnt_nxt = fifo_cnt - ONE_CNT;
         default: fifo_cnt_nxt = fifo_cnt;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of block ordering.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc    <= START_PC;
         resp_pc     <= START_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding_nxt;
         drop_cnt    <= drop_nxt;
         if (branch_taken) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
         end else begin
            if (req_xfer) fetch_pc <= fetch_pc + 64'd4;
            if (push)     resp_pc  <= resp_pc + 64'd4;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else if (branch_taken) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         fifo_cnt <= fifo_cnt_nxt;
         if (push) wr_ptr <= wr_ptr + ONE_PTR;
         if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
      end
   end

   // NOTE: buffer storage is deliberately not reset; fifo_cnt alone decides
   // which entries are valid, and the outputs mux in NOP/0 when empty.
   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= imem_rdata;
         pc_mem[wr_ptr]    <= resp_pc;
      end
   end

   a_no_push_when_full : assert property (
      @(posedge clk) disable iff (!reset_n) !(push && fifo_full)
   );

endmodule
